// File: rtl/bcd_serial_addsub_pkg.sv
// Shared types and constants for the digit-serial packed-BCD adder/subtractor.
// Package name is bcd_pkg; imported by bcd_digit_add and bcd_serial_addsub.
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;
   localparam bcd_digit_t BCD_ADJ = 4'd6;

   function automatic logic is_bcd_digit(input bcd_digit_t d);
      return (d <= BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_serial_addsub_digit_add.sv
// Combinational single-digit BCD adder with decimal correction.
// The caller supplies the already-complemented B digit when subtracting.
module bcd_digit_add
   import bcd_pkg::*;
(
   input  bcd_digit_t a_dig,
   input  bcd_digit_t b_dig,
   input  logic       cin,
   output bcd_digit_t s_dig,
   output logic       cout
);

   logic [4:0] raw;

   // Binary sum spans 0..19; above 9 the +6 skips the six unused codes
   always_comb begin
      raw = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, cin};
      if (raw > {1'b0, BCD_MAX}) begin
         s_dig = raw[3:0] + BCD_ADJ;
         cout  = 1'b1;
      end else begin
         s_dig = raw[3:0];
         cout  = 1'b0;
      end
   end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// Define BCD_SUB_EN to build subtraction (A + 9's complement of B + 1).
module bcd_serial_addsub
   import bcd_pkg::*;
#(
   parameter int NDIG = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_valid,
   output logic            start_ready,
   input  logic            op,
   input  logic [4*NDIG-1:0] a,
   input  logic [4*NDIG-1:0] b,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [4*NDIG-1:0] sum,
   output logic            carry_out,
   output logic            neg,
   output logic            invalid,
   output logic            busy
);

   localparam int W  = 4 * NDIG;
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

   state_t         state;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic [W-1:0]   sum_q;
   logic [IW-1:0]  idx;
   logic           carry_q;
   logic           carry_out_q;
   logic           invalid_q;
   logic           any_bad;
   logic           init_carry;
   bcd_digit_t     a_dig;
   bcd_digit_t     b_dig;
   bcd_digit_t     b_eff;
   bcd_digit_t     s_dig;
   logic           dig_cout;

   // Screen every operand digit at accept so bad input never reaches RUN
   always_comb begin
      any_bad = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if (!is_bcd_digit(a[4*i +: 4]) || !is_bcd_digit(b[4*i +: 4])) begin
            any_bad = 1'b1;
         end
      end
   end

   assign a_dig = a_q[idx*4 +: 4];
   assign b_dig = b_q[idx*4 +: 4];

`ifdef BCD_SUB_EN
   logic op_q;
   logic neg_q;

   assign b_eff      = op_q ? bcd_digit_t'(BCD_MAX - b_dig) : b_dig;
   assign init_carry = op;
   assign neg        = neg_q;
`else
   logic unused_op;

   assign unused_op  = op;
   assign b_eff      = b_dig;
   assign init_carry = 1'b0;
   assign neg        = 1'b0;
`endif

   bcd_digit_add u_digit_add (
      .a_dig (a_dig),
      .b_dig (b_eff),
      .cin   (carry_q),
      .s_dig (s_dig),
      .cout  (dig_cout)
   );

   // Control FSM plus datapath registers; result fields only change on accept or in RUN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         idx         <= '0;
         carry_q     <= 1'b0;
         carry_out_q <= 1'b0;
         invalid_q   <= 1'b0;
`ifdef BCD_SUB_EN
         op_q        <= 1'b0;
         neg_q       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  a_q         <= a;
                  b_q         <= b;
                  sum_q       <= '0;
                  idx         <= '0;
                  carry_q     <= init_carry;
                  carry_out_q <= 1'b0;
                  invalid_q   <= any_bad;
`ifdef BCD_SUB_EN
                  op_q        <= op;
                  neg_q       <= 1'b0;
`endif
                  state       <= any_bad ? DONE : RUN;
               end
            end
            RUN: begin
               sum_q[idx*4 +: 4] <= s_dig;
               carry_q           <= dig_cout;
               if (idx == IW'(NDIG - 1)) begin
                  carry_out_q <= dig_cout;
`ifdef BCD_SUB_EN
                  neg_q       <= op_q & ~dig_cout;
`endif
                  state       <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (res_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign start_ready = (state == IDLE);
   assign res_valid   = (state == DONE);
   assign busy        = (state != IDLE);
   assign sum         = sum_q;
   assign carry_out   = carry_out_q;
   assign invalid     = invalid_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Self-checking bench for bcd_serial_addsub (NDIG=4) against an integer decimal model.
// Honours BCD_SUB_EN the same way the design does.
module tb_bcd_serial_addsub;

   localparam int NDIG = 4;
   localparam int W    = 4 * NDIG;
   localparam int MOD  = 10000;

   logic         clk;
   logic         rst_n;
   logic         start_valid;
   logic         start_ready;
   logic         op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         res_valid;
   logic         res_ready;
   logic [W-1:0] sum;
   logic         carry_out;
   logic         neg;
   logic         invalid;
   logic         busy;

   int checkCount;
   int passCount;

   bcd_serial_addsub #(.NDIG(NDIG)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .op          (op),
      .a           (a),
      .b           (b),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .sum         (sum),
      .carry_out   (carry_out),
      .neg         (neg),
      .invalid     (invalid),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic int bcdToInt(input logic [W-1:0] v);
      int r;
      r = 0;
      for (int i = NDIG - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
      return r;
   endfunction

   function automatic logic [W-1:0] intToBcd(input int n);
      logic [W-1:0] r;
      int m;
      m = n;
      for (int i = 0; i < NDIG; i++) begin
         r[i*4 +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return r;
   endfunction

   function automatic logic hasBadDigit(input logic [W-1:0] v);
      for (int i = 0; i < NDIG; i++) if (v[i*4 +: 4] > 4'd9) return 1'b1;
      return 1'b0;
   endfunction

   // Decimal reference: plain integer arithmetic on the operand values
   task automatic modelResult(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic top,
                              output logic [W-1:0] eSum, output logic eC, output logic eN,
                              output logic eI, output int eLat);
      int ia, ib, total;
      logic doSub;
`ifdef BCD_SUB_EN
      doSub = top;
`else
      doSub = 1'b0;
`endif
      eSum = '0; eC = 1'b0; eN = 1'b0; eI = 1'b0; eLat = NDIG + 1;
      if (hasBadDigit(ta) || hasBadDigit(tb)) begin
         eI   = 1'b1;
         eLat = 1;
      end else begin
         ia = bcdToInt(ta);
         ib = bcdToInt(tb);
         if (doSub) begin
            if (ia >= ib) begin
               eSum = intToBcd(ia - ib);
               eC   = 1'b1;
            end else begin
               eSum = intToBcd(MOD - (ib - ia));
               eN   = 1'b1;
            end
         end else begin
            total = ia + ib;
            eSum  = intToBcd(total % MOD);
            eC    = (total >= MOD);
         end
      end
   endtask

   // One full operation: accept, latency, optional back-pressure, result handshake
   task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic top,
                                input int hold, input string tag);
      logic [W-1:0] eSum;
      logic eC, eN, eI;
      int eLat, edges;
      modelResult(ta, tb, top, eSum, eC, eN, eI, eLat);
      edges = 0;
      while (!start_ready && edges < 100) begin
         @(posedge clk); #1; edges++;
      end
      checkOutput({tag, ".idle"}, start_ready, 1'b1);
      a = ta; b = tb; op = top;
      start_valid = 1'b1;
      res_ready   = (hold == 0);
      edges = 0;
      do begin
         @(posedge clk); #1; edges++;
         if (edges == 1) begin
            start_valid = 1'b0;
            a  = W'($urandom);
            b  = W'($urandom);
            op = 1'($urandom);
         end
      end while (!res_valid && edges < 100);
      checkOutput({tag, ".latency"}, edges, eLat);
      for (int i = 0; i < hold; i++) begin
         start_valid = 1'b1;
         @(posedge clk); #1;
         checkOutput({tag, ".holdvalid"}, {res_valid, start_ready}, 2'b10);
         checkOutput({tag, ".holdsum"}, sum, eSum);
      end
      res_ready = 1'b1;
      checkOutput({tag, ".sum"}, sum, eSum);
      checkOutput({tag, ".flags"}, {carry_out, neg, invalid}, {eC, eN, eI});
      @(posedge clk); #1;
      checkOutput({tag, ".release"}, {start_ready, res_valid, busy}, 3'b100);
      checkOutput({tag, ".keptsum"}, sum, eSum);
      start_valid = 1'b0;
      res_ready   = 1'b0;
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      checkCount  = 0;
      passCount   = 0;
      rst_n       = 1'b0;
      start_valid = 1'b0;
      res_ready   = 1'b0;
      op          = 1'b0;
      a           = '0;
      b           = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset.ctrl", {start_ready, res_valid, busy}, 3'b100);
      checkOutput("reset.res", {sum, carry_out, neg, invalid}, '0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      applyStimulus(16'h4567, 16'h5678, 1'b0, 0, "add4567");
      applyStimulus(16'h9999, 16'h0001, 1'b0, 0, "add9999");
      applyStimulus(16'h0000, 16'h0000, 1'b0, 0, "addzero");
      applyStimulus(16'h12A4, 16'h0000, 1'b0, 0, "badA");
      applyStimulus(16'h5000, 16'h1234, 1'b1, 0, "sub5000");
      applyStimulus(16'h1234, 16'h5000, 1'b1, 6, "sub1234hold");

      // Asynchronous reset while the second digit is in flight
      a = 16'h1234; b = 16'h1111; op = 1'b0; start_valid = 1'b1; res_ready = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst.ctrl", {start_ready, res_valid, busy}, 3'b100);
      checkOutput("midrst.res", {sum, carry_out, neg, invalid}, '0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      res_ready = 1'b0;
      applyStimulus(16'h0001, 16'h0002, 1'b0, 0, "fresh");

      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < NDIG; i++) begin
            ra[i*4 +: 4] = 4'($urandom_range(0, 9));
            rb[i*4 +: 4] = 4'($urandom_range(0, 9));
         end
         if ($urandom_range(0, 7) == 0) ra[$urandom_range(0, NDIG-1)*4 +: 4] = 4'($urandom_range(10, 15));
         if ($urandom_range(0, 7) == 0) rb[$urandom_range(0, NDIG-1)*4 +: 4] = 4'($urandom_range(10, 15));
         applyStimulus(ra, rb, 1'($urandom), int'($urandom_range(0, 3)), "rand");
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
